// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared defaults and types for the register-file writeback scheduler and
// the scalar register file it drives.
package regfile_wb_scheduler_pkg;

  localparam int REGISTERS_DEF = 32;
  localparam int WIDTH_DEF     = 32;
  localparam int NREQ_DEF      = 3;
  localparam int ADDR_W        = $clog2(REGISTERS_DEF);

  typedef logic [ADDR_W-1:0]    reg_addr_t;
  typedef logic [WIDTH_DEF-1:0] reg_data_t;

  // Round-robin successor of a granted index, wrapping modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins,
// and the grant is one-hot or all zero.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: arbitrates register-file write requests and keeps a
// busy scoreboard that stalls issue on RAW and WAW hazards.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int REGISTERS = REGISTERS_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NREQ      = NREQ_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NREQ-1:0]                          req_valid,
  input  logic [NREQ-1:0][$clog2(REGISTERS)-1:0]   req_addr,
  input  logic [NREQ-1:0][WIDTH-1:0]               req_data,
  output logic [NREQ-1:0]                          req_ready,
  input  logic                                     issue_valid,
  input  logic [$clog2(REGISTERS)-1:0]             issue_rd,
  input  logic [$clog2(REGISTERS)-1:0]             issue_rs1,
  input  logic [$clog2(REGISTERS)-1:0]             issue_rs2,
  output logic                                     issue_stall,
  output logic                                     we3,
  output logic [$clog2(REGISTERS)-1:0]             a3,
  output logic [WIDTH-1:0]                         wd3,
  output logic [REGISTERS-1:0]                     busy
);

  localparam int AW = $clog2(REGISTERS);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      grant;
  logic [PW-1:0]        grant_idx;
  logic                 handshake;
  logic                 we3_q, we3_d;
  logic [AW-1:0]        a3_q, a3_d;
  logic [WIDTH-1:0]     wd3_q, wd3_d;
  logic [REGISTERS-1:0] busy_q, busy_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Grants are suppressed during reset so no handshake can be seen then.
  assign req_ready   = rst_n ? grant : '0;
  assign handshake   = |(req_valid & req_ready);
  assign issue_stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);

  assign we3  = we3_q;
  assign a3   = a3_q;
  assign wd3  = wd3_q;
  assign busy = busy_q;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  always_comb begin
    we3_d    = handshake;
    a3_d     = a3_q;
    wd3_d    = wd3_q;
    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      a3_d     = req_addr[grant_idx];
      wd3_d    = req_data[grant_idx];
      rr_ptr_d = PW'(rr_next(int'(grant_idx), NREQ));
    end
  end

  // Clear is applied first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (we3_q) busy_d[a3_q] = 1'b0;
    if (issue_valid && !issue_stall) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q    <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      we3_q    <= we3_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have parameter REGISTERS, default 32, number of scalar registers.
REQ-002 SHALL have parameter WIDTH, default 32, data width.
REQ-003 SHALL have parameter NREQ, default 3, number of writeback requesters.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester writeback request.
REQ-007 SHALL have port req_addr  in  NREQ x clog2(REGISTERS)  per-requester destination register.
REQ-008 SHALL have port req_data  in  NREQ x WIDTH  per-requester writeback data.
REQ-009 SHALL have port req_ready  out  NREQ  one-hot grant, combinational.
REQ-010 SHALL have port issue_valid  in  1  issue stage presents an instruction.
REQ-011 SHALL have ports issue_rd, issue_rs1, issue_rs2  in  clog2(REGISTERS) each  destination and sources of the issuing instruction.
REQ-012 SHALL have port issue_stall  out  1  hazard, issue must hold.
REQ-013 SHALL have ports we3  out  1, a3  out  clog2(REGISTERS), wd3  out  WIDTH  register file write port drive.
REQ-014 SHALL have port busy  out  REGISTERS  scoreboard, one bit per register.

Function
REQ-015 SHALL complete a write handshake for requester i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid high.
REQ-017 SHALL arbitrate round-robin: search starts at rr_ptr, wraps modulo NREQ, and the first valid requester wins.
REQ-018 SHALL set rr_ptr to (granted index + 1) mod NREQ after each handshake, and hold rr_ptr when no grant occurs.
REQ-019 SHALL register the handshake: we3=1, a3=req_addr[i], wd3=req_data[i] in the cycle after the handshake.
REQ-020 SHALL drive we3=0 in any cycle not following a handshake, with a3/wd3 holding their last values.
REQ-021 SHALL set busy[issue_rd] at the clock edge when issue_valid=1 and issue_stall=0.
REQ-022 SHALL clear busy[a3] at the clock edge ending a cycle with we3=1, so the write commits before any consumer is released.
REQ-023 SHALL let set win over clear on a simultaneous set and clear of the same register.
REQ-024 SHALL compute issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]), which covers RAW and WAW.
REQ-025 SHALL leave busy unaffected by a write handshake to a register whose busy bit is 0; the write still occurs.
REQ-026 SHALL treat all REGISTERS addresses identically, with no hardwired register.
REQ-027 SHALL sustain one write per cycle under continuous requests, with no bubble cycles.

Reset
REQ-028 SHALL force, while rst_n=0 (asynchronously): we3=0, a3=0, wd3=0, busy=0, rr_ptr=0.
REQ-029 SHALL force req_ready=0 while rst_n=0.
REQ-030 SHALL drop any handshake in flight when reset is asserted mid-operation; no write is issued after reset release.

Structure
REQ-031 SHALL place REGISTERS/WIDTH defaults and the register-address typedef in a shared package, used with register_file_escalar.
REQ-032 SHALL implement the round-robin arbiter as sub-module rr_arbiter (NREQ, req, ptr -> one-hot grant).
REQ-033 SHALL keep the scoreboard inside regfile_wb_scheduler.

Verification
REQ-034 SHALL verify single write: req_valid=001, addr=5, data=ABCDEFFF -> req_ready=001 same cycle; next cycle we3=1, a3=5, wd3=ABCDEFFF.
REQ-035 SHALL verify fairness: all three valid for 6 cycles from reset -> grants 0,1,2,0,1,2 with we3 high for 6 consecutive cycles.
REQ-036 SHALL verify RAW stall: issue rd=1, then issue rs1=1 -> issue_stall=1 until one cycle after we3=1 with a3=1, then 0.
REQ-037 SHALL verify set/clear collision: we3 to reg 7 while issuing rd=7 -> busy[7] remains 1.
REQ-038 SHALL verify WAW: busy[3]=1, issue rd=3 -> issue_stall=1 and busy unchanged.
REQ-039 SHALL verify mid-operation reset: rst_n low in the handshake cycle -> we3 stays 0, busy=0, and the next grant goes to requester 0.
